id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage feeding the 32-bit EX ALU. Registers the decoded instruction fields from ID, resolves RAW hazards by forwarding from EX/MEM (the ALU's registered result) and MEM/WB, and detects load-use hazards by stalling ID and inserting a one-cycle bubble. Its outputs drive the ALU's operand, control and shift-amount inputs directly, plus the side-band control carried to MEM/WB.

## Interface
- DATA_W, 32, operand/result width
- RADDR_W, 5, register-address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr  in  RADDR_W  source registers
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_use_imm  in  1  operand 2 = immediate (ALUSrc)
- id_alu_ctrl  in  4  ALU opcode (ADD=0 … NOR=9)
- id_shamt  in  5  shift amount
- id_dst_addr  in  RADDR_W  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- flush  in  1  branch taken, squash ID
- exm_reg_write  in  1 ; exm_dst_addr  in  RADDR_W ; exm_result  in  DATA_W  EX/MEM forward source
- mwb_reg_write  in  1 ; mwb_dst_addr  in  RADDR_W ; mwb_data  in  DATA_W  MEM/WB forward source
- stall_id  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_data1, ex_data2  out  DATA_W  ALU operands (forwarded)
- ex_alu_ctrl  out  4 ; ex_shamt  out  5  ALU control
- ex_store_data  out  DATA_W  forwarded rt for stores
- ex_dst_addr  out  RADDR_W ; ex_reg_write, ex_mem_read, ex_mem_write  out  1

## Operation
- ID/EX register fields: valid, rs/rt addr, rs/rt data, imm, use_imm, alu_ctrl, shamt, dst_addr, reg_write, mem_read, mem_write.
- Per-edge update priority: rst > flush > load-use bubble > load.
  - rst: all fields 0.
  - flush or bubble: valid, reg_write, mem_read and mem_write are 0. Other fields don't-care; implement them as 0.
  - Otherwise: load the ID fields. The control bits are ANDed with id_valid.
- Load-use hazard (combinational) is asserted when all of the following hold:
  - ex_mem_read=1 and ex_dst_addr≠0;
  - id_valid=1;
  - ex_dst_addr equals id_rs_addr, or equals id_rt_addr when (id_use_imm=0 or id_mem_write=1).
- stall_id = hazard & ~flush.
- Forwarding runs combinationally on the registered rs and rt separately:
  - EX/MEM if exm_reg_write and exm_dst_addr≠0 and the addresses match;
  - else MEM/WB under the same rule;
  - else the registered read data.
  - EX/MEM wins over MEM/WB. Register 0 is never forwarded.
- Output selects:
  - ex_data1 = forwarded rs.
  - ex_store_data = forwarded rt.
  - ex_data2 = registered imm if use_imm, else forwarded rt.
- The register file is write-before-read; this block has no WB-to-ID bypass.
- ALU overflow is not consumed here.

## Timing
- One cycle ID→EX. Fields present at edge t drive ex_* during cycle t+1. The ALU latches its result at edge t+2.
- The load-use stall lasts exactly one cycle. After the bubble, ID/EX no longer holds the load, so the hazard drops and the dependent instruction takes the MEM/WB forward on the following cycle.
- Simultaneous flush and hazard: flush wins. stall_id=0 and a bubble is inserted.
- rst mid-stall: the next cycle has ex_valid=0 and stall_id=0.
- Reset values: every registered field is 0. ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0. ex_data1, ex_data2, ex_store_data, ex_alu_ctrl (ADD), ex_shamt, ex_dst_addr = 0. stall_id=0 with id_valid=0.

## Structure
- Shared package `mips_pkg`:
  - ALU opcode constants ALU_ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRL=5, SRA=6, SGT=7, SLT=8, NOR=9 (shared with the ALU and the decoder).
  - Forward-select enum {FWD_REG, FWD_EXM, FWD_MWB}.
  - DATA_W and RADDR_W defaults.
- One combinational sub-module `forward_unit`: inputs are the src addr and both forward sources; output is the select. Instantiate it twice (rs, rt).

## Test plan
- Reset: hold rst 2 cycles with random ID inputs → every ex_* output is 0 and stall_id=0. The first loaded instruction appears one cycle after rst drops.
- EX/MEM forward: `add $3,$1,$2` followed by `sub $4,$3,$5`, exm_result=0x0000_0010 → ex_data1=0x10 for the sub. When MEM/WB also targets $3 with 0x99, the result is still 0x10.
- MEM/WB forward and $0: mwb_dst=7, mwb_data=0xDEAD_BEEF, rt=7, use_imm=0 → ex_data2=0xDEADBEEF. With exm_dst=0 and reg_write=1, no forward occurs.
- Load-use: `lw $8` in ID/EX and ID `add $9,$8,$1` → stall_id=1 for one cycle and ex_valid=0 the next cycle. The add then issues with the rs operand taken from mwb_data.
- Immediate store: `sw $8,4($2)` after `lw $8` → stall, because rt is checked for stores. Then ex_data2=4 and ex_store_data=forwarded $8.
- Flush with hazard: flush=1 while the load-use condition holds → stall_id=0, ex_valid=0 and ex_reg_write=0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS-style pipeline: ALU opcode encodings (used
// by the decoder, the ID/EX stage and the ALU), the forwarding-select enum and
// default datapath/register-address widths.
// ---------------------------------------------------------------------------
package mips_pkg;

    // Default widths for the 32-bit datapath and the 32-entry register file
    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_RADDR_W = 5;

    // ALU opcode encodings
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SRA = 4'd6;
    localparam logic [3:0] ALU_SGT = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;
    localparam logic [3:0] ALU_NOR = 4'd9;

    // Where an EX operand is taken from
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,   // value latched from the register file in ID
        FWD_EXM = 2'd1,   // EX/MEM registered ALU result
        FWD_MWB = 2'd2    // MEM/WB write-back data
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
// Combinational forwarding select for one EX source operand.
// Ports:
//   src_addr                    register address the operand was read from
//   exm_reg_write, exm_dst_addr EX/MEM producer (writes and its destination)
//   mwb_reg_write, mwb_dst_addr MEM/WB producer (writes and its destination)
//   fwd_sel                     chosen source (FWD_REG / FWD_EXM / FWD_MWB)
// ---------------------------------------------------------------------------
module forward_unit
    import mips_pkg::*;
#(
    parameter int RADDR_W = DEFAULT_RADDR_W
) (
    input  logic [RADDR_W-1:0] src_addr,
    input  logic               exm_reg_write,
    input  logic [RADDR_W-1:0] exm_dst_addr,
    input  logic               mwb_reg_write,
    input  logic [RADDR_W-1:0] mwb_dst_addr,
    output fwd_sel_e           fwd_sel
);

    logic exm_hit;
    logic mwb_hit;

    // A producer only counts if it really writes, targets the same register,
    // and that register is not $0 (which is hardwired to zero and must never
    // pick up a stale in-flight value).
    always_comb begin
        exm_hit = exm_reg_write && (exm_dst_addr != '0) && (exm_dst_addr == src_addr);
        mwb_hit = mwb_reg_write && (mwb_dst_addr != '0) && (mwb_dst_addr == src_addr);
    end

    // The younger producer (EX/MEM) holds the newest value, so it wins over
    // MEM/WB when both match.
    always_comb begin
        fwd_sel = FWD_REG;
        if (exm_hit) begin
            fwd_sel = FWD_EXM;
        end else if (mwb_hit) begin
            fwd_sel = FWD_MWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register feeding the EX ALU. Registers the decoded fields,
// forwards EX/MEM and MEM/WB results onto the registered rs/rt operands, and
// detects load-use hazards (stall ID for one cycle, insert a bubble).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_*                        decoded instruction fields from ID
//   flush                       branch taken: squash the instruction in ID
//   exm_*                       EX/MEM forward source
//   mwb_*                       MEM/WB forward source
//   stall_id                    hold PC and IF/ID this cycle
//   ex_valid, ex_data1/2,
//   ex_alu_ctrl, ex_shamt       ALU operands and control
//   ex_store_data               forwarded rt for stores
//   ex_dst_addr, ex_reg_write,
//   ex_mem_read, ex_mem_write   side-band control carried to MEM/WB
// ---------------------------------------------------------------------------
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int RADDR_W = DEFAULT_RADDR_W
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs_addr,
    input  logic [RADDR_W-1:0] id_rt_addr,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_use_imm,
    input  logic [3:0]         id_alu_ctrl,
    input  logic [4:0]         id_shamt,
    input  logic [RADDR_W-1:0] id_dst_addr,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,

    input  logic               flush,

    input  logic               exm_reg_write,
    input  logic [RADDR_W-1:0] exm_dst_addr,
    input  logic [DATA_W-1:0]  exm_result,

    input  logic               mwb_reg_write,
    input  logic [RADDR_W-1:0] mwb_dst_addr,
    input  logic [DATA_W-1:0]  mwb_data,

    output logic               stall_id,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_data1,
    output logic [DATA_W-1:0]  ex_data2,
    output logic [3:0]         ex_alu_ctrl,
    output logic [4:0]         ex_shamt,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic [RADDR_W-1:0] ex_dst_addr,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write
);

    // ID/EX pipeline register fields
    logic               valid_q;
    logic [RADDR_W-1:0] rs_addr_q;
    logic [RADDR_W-1:0] rt_addr_q;
    logic [DATA_W-1:0]  rs_data_q;
    logic [DATA_W-1:0]  rt_data_q;
    logic [DATA_W-1:0]  imm_q;
    logic               use_imm_q;
    logic [3:0]         alu_ctrl_q;
    logic [4:0]         shamt_q;
    logic [RADDR_W-1:0] dst_addr_q;
    logic               reg_write_q;
    logic               mem_read_q;
    logic               mem_write_q;

    logic               load_use;
    logic               rt_is_source;
    fwd_sel_e           rs_sel;
    fwd_sel_e           rt_sel;
    logic [DATA_W-1:0]  rs_fwd;
    logic [DATA_W-1:0]  rt_fwd;

    // Load-use detection. The rt field only counts as a source when the
    // instruction really reads it: R-type (no immediate) or a store, whose
    // rt is the data to be written. For other immediate forms rt is the
    // destination and must not trigger a stall.
    always_comb begin
        rt_is_source = !id_use_imm || id_mem_write;
        load_use     = mem_read_q && (dst_addr_q != '0) && id_valid &&
                       ((dst_addr_q == id_rs_addr) ||
                        ((dst_addr_q == id_rt_addr) && rt_is_source));
    end

    // A taken branch squashes the instruction in ID anyway, so there is no
    // point holding it; flush overrides the stall.
    assign stall_id = load_use && !flush;

    // Pipeline register. Reset, flush and the load-use bubble all leave an
    // all-zero (invalid, side-effect free) entry; otherwise the ID fields are
    // captured with control bits qualified by id_valid so a non-instruction
    // can never write registers or memory.
    always_ff @(posedge clk) begin
        if (rst || flush || load_use) begin
            valid_q     <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            alu_ctrl_q  <= ALU_ADD;
            shamt_q     <= '0;
            dst_addr_q  <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= id_valid;
            rs_addr_q   <= id_rs_addr;
            rt_addr_q   <= id_rt_addr;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            use_imm_q   <= id_use_imm;
            alu_ctrl_q  <= id_alu_ctrl;
            shamt_q     <= id_shamt;
            dst_addr_q  <= id_dst_addr;
            reg_write_q <= id_reg_write && id_valid;
            mem_read_q  <= id_mem_read  && id_valid;
            mem_write_q <= id_mem_write && id_valid;
        end
    end

    forward_unit #(.RADDR_W(RADDR_W)) u_fwd_rs (
        .src_addr      (rs_addr_q),
        .exm_reg_write (exm_reg_write),
        .exm_dst_addr  (exm_dst_addr),
        .mwb_reg_write (mwb_reg_write),
        .mwb_dst_addr  (mwb_dst_addr),
        .fwd_sel       (rs_sel)
    );

    forward_unit #(.RADDR_W(RADDR_W)) u_fwd_rt (
        .src_addr      (rt_addr_q),
        .exm_reg_write (exm_reg_write),
        .exm_dst_addr  (exm_dst_addr),
        .mwb_reg_write (mwb_reg_write),
        .mwb_dst_addr  (mwb_dst_addr),
        .fwd_sel       (rt_sel)
    );

    // Operand muxes driven by the forwarding selects
    always_comb begin
        rs_fwd = rs_data_q;
        case (rs_sel)
            FWD_EXM: rs_fwd = exm_result;
            FWD_MWB: rs_fwd = mwb_data;
            default: rs_fwd = rs_data_q;
        endcase

        rt_fwd = rt_data_q;
        case (rt_sel)
            FWD_EXM: rt_fwd = exm_result;
            FWD_MWB: rt_fwd = mwb_data;
            default: rt_fwd = rt_data_q;
        endcase
    end

    // ALU operand 2 is the immediate for I-type forms; the forwarded rt is
    // still exported separately because stores need it as write data.
    assign ex_data1      = rs_fwd;
    assign ex_data2      = use_imm_q ? imm_q : rt_fwd;
    assign ex_store_data = rt_fwd;

    assign ex_valid      = valid_q;
    assign ex_alu_ctrl   = alu_ctrl_q;
    assign ex_shamt      = shamt_q;
    assign ex_dst_addr   = dst_addr_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;

endmodule
